// File: rtl/gate_bist_checker.sv
// -----------------------------------------------------------------------------
// gate_bist_checker
//
// Built-in self test controller for the basic-gate unit. It walks the gate
// inputs {a,b} through 00,01,10,11 (repeated PASSES times). Each vector is held
// for SETTLE_CYCLES cycles and is then checked for one cycle. In the check
// cycle the seven gate responses are compared with their golden values. At the
// end of a run the block reports pass/fail, a saturating count of mismatching
// vectors and a sticky per-output failure mask.
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held before its check cycle (>= 1)
//   PASSES         number of full 4-vector sweeps per run (>= 1)
//   ERR_W          width of err_cnt
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (aborts a run, no done pulse)
//   start      begin a run; only sampled while idle
//   a, b       registered stimulus to the gate unit
//   ny..xny    gate unit responses, sampled only in the check cycle
//   busy       high from the cycle after start is accepted until DONE exits
//   done       one-cycle pulse at the end of a run
//   pass       1 iff no vector mismatched; held until the next accepted start
//   err_cnt    mismatching vectors, saturating at all-ones
//   fail_vec   sticky mask {ny,ay,oy,nay,noy,xoy,xny} of outputs that mismatched
//
// Optional feature (macro GATE_BIST_FAILLOG_EN)
//   Adds first_fail_valid / first_fail_ab / first_fail_resp. These capture the
//   stimulus and the raw response of the first failing check since start.
// -----------------------------------------------------------------------------
module gate_bist_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             ny,
    input  logic             ay,
    input  logic             oy,
    input  logic             nay,
    input  logic             noy,
    input  logic             xoy,
    input  logic             xny,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [6:0]       fail_vec
`ifdef GATE_BIST_FAILLOG_EN
    ,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_ab,
    output logic [6:0]       first_fail_resp
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SW_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SW_W-1:0] SWEEP_LAST  = SW_W'(PASSES - 1);

    logic [1:0]       state;
    logic [SC_W-1:0]  settle_cnt;
    logic [SW_W-1:0]  sweep;

    logic [6:0]       resp;
    logic [6:0]       expected;
    logic [6:0]       mism;
    logic [ERR_W-1:0] err_cnt_next;
    logic [1:0]       ab_next;
    logic             last_vec;

    always_comb begin
        resp     = {ny, ay, oy, nay, noy, xoy, xny};
        expected = {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        mism     = resp ^ expected;

        // Saturating increment: once all-ones the count stays there.
        err_cnt_next = err_cnt;
        if ((|mism) && (err_cnt != '1)) begin
            err_cnt_next = err_cnt + ERR_W'(1);
        end

        ab_next  = {a, b} + 2'd1;
        last_vec = ({a, b} == 2'b11) && (sweep == SWEEP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            settle_cnt <= '0;
            sweep      <= '0;
`ifdef GATE_BIST_FAILLOG_EN
            first_fail_valid <= 1'b0;
            first_fail_ab    <= '0;
            first_fail_resp  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a          <= 1'b0;
                        b          <= 1'b0;
                        err_cnt    <= '0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        sweep      <= '0;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
`ifdef GATE_BIST_FAILLOG_EN
                        first_fail_valid <= 1'b0;
                        first_fail_ab    <= '0;
                        first_fail_resp  <= '0;
`endif
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                    end
                end

                ST_CHECK: begin
                    fail_vec <= fail_vec | mism;
                    err_cnt  <= err_cnt_next;
`ifdef GATE_BIST_FAILLOG_EN
                    if ((|mism) && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_ab    <= {a, b};
                        first_fail_resp  <= resp;
                    end
`endif
                    if (last_vec) begin
                        // pass must include this final check, hence err_cnt_next.
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= (err_cnt_next == '0);
                    end else begin
                        {a, b}     <= ab_next;
                        settle_cnt <= '0;
                        if ({a, b} == 2'b11) begin
                            sweep <= sweep + SW_W'(1);
                        end
                        state <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
`timescale 1ns/1ps
module tb_gate_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic sel;
    int   total = 0;
    int   bad   = 0;

    logic [6:0] m_s0, m_s1, m_inv, noise;

    // instance 0: defaults; instance 1: SETTLE_CYCLES=1, PASSES=3, ERR_W=2
    logic       a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [6:0] fv0, r0;
    logic       a1, b1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [6:0] fv1, r1;
`ifdef GATE_BIST_FAILLOG_EN
    logic       ffv0, ffv1;
    logic [1:0] ffab0, ffab1;
    logic [6:0] ffr0, ffr1;
    logic       offv;
    logic [1:0] offab;
    logic [6:0] offr;
`endif

    function automatic logic [6:0] golden(input logic x, input logic y);
        logic [6:0] g;
        g[6] = !x;
        g[5] = x && y;
        g[4] = x || y;
        g[3] = !(x && y);
        g[2] = !(x || y);
        g[1] = (x != y);
        g[0] = (x == y);
        return g;
    endfunction

    function automatic logic [6:0] faulty(input logic [6:0] g, input logic [6:0] s0,
                                          input logic [6:0] s1, input logic [6:0] inv);
        return ((g ^ inv) & ~s0) | s1;
    endfunction

    always_comb begin
        r0 = faulty(golden(a0, b0), m_s0, m_s1, m_inv) ^ (sel ? 7'd0 : noise);
        r1 = faulty(golden(a1, b1), m_s0, m_s1, m_inv) ^ (sel ? noise : 7'd0);
    end

    gate_bist_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel), .a(a0), .b(b0),
        .ny(r0[6]), .ay(r0[5]), .oy(r0[4]), .nay(r0[3]), .noy(r0[2]), .xoy(r0[1]), .xny(r0[0]),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
`ifdef GATE_BIST_FAILLOG_EN
        , .first_fail_valid(ffv0), .first_fail_ab(ffab0), .first_fail_resp(ffr0)
`endif
    );

    gate_bist_checker #(.SETTLE_CYCLES(1), .PASSES(3), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & sel), .a(a1), .b(b1),
        .ny(r1[6]), .ay(r1[5]), .oy(r1[4]), .nay(r1[3]), .noy(r1[2]), .xoy(r1[1]), .xny(r1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
`ifdef GATE_BIST_FAILLOG_EN
        , .first_fail_valid(ffv1), .first_fail_ab(ffab1), .first_fail_resp(ffr1)
`endif
    );

    logic       oa, ob, obusy, odone, opass;
    logic [7:0] oerr;
    logic [6:0] ofv;
    always_comb begin
        oa    = sel ? a1 : a0;
        ob    = sel ? b1 : b0;
        obusy = sel ? busy1 : busy0;
        odone = sel ? done1 : done0;
        opass = sel ? pass1 : pass0;
        oerr  = sel ? {6'd0, err1} : err0;
        ofv   = sel ? fv1 : fv0;
`ifdef GATE_BIST_FAILLOG_EN
        offv  = sel ? ffv1 : ffv0;
        offab = sel ? ffab1 : ffab0;
        offr  = sel ? ffr1 : ffr0;
`endif
    end

    // Reference model of one run: cumulative results after each checked vector.
    int         cum_err [0:15];
    logic [6:0] cum_fv  [0:15];
    int         first_idx;
    logic [1:0] first_ab;
    logic [6:0] first_resp;

    task automatic build_model(input int p, input int ew);
        int nv, maxv;
        logic [1:0] ab;
        logic [6:0] g, f;
        nv = 4 * p;
        maxv = (1 << ew) - 1;
        cum_err[0] = 0;
        cum_fv[0] = 7'd0;
        first_idx = -1;
        first_ab = 2'd0;
        first_resp = 7'd0;
        for (int v = 0; v < nv; v++) begin
            ab = 2'(v % 4);
            g = golden(ab[1], ab[0]);
            f = faulty(g, m_s0, m_s1, m_inv);
            cum_err[v+1] = cum_err[v] + ((f != g) ? 1 : 0);
            if (cum_err[v+1] > maxv) cum_err[v+1] = maxv;
            cum_fv[v+1] = cum_fv[v] | (f ^ g);
            if (f != g && first_idx < 0) begin
                first_idx = v;
                first_ab = ab;
                first_resp = f;
            end
        end
    endtask

    // One full run on the selected instance, checked every cycle against the model.
    // inj >= 0 re-pulses start during cycle inj of the run (must be ignored).
    task automatic run_check(input string name, input int inj, input bit glitch);
        int s, p, ew, len, nv, vd;
        logic [1:0] exp_ab;
        logic exp_busy, exp_done, exp_pass;
        s  = sel ? 1 : 2;
        p  = sel ? 3 : 1;
        ew = sel ? 2 : 8;
        len = 4 * p * (s + 1);
        nv = 4 * p;
        build_model(p, ew);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c <= len + 1; c++) begin
            noise = (glitch && c < len && (c % (s + 1)) != s) ? 7'($urandom) : 7'd0;
            vd = c / (s + 1);
            if (vd > nv) vd = nv;
            exp_ab   = (c < len) ? 2'((c / (s + 1)) % 4) : 2'b11;
            exp_busy = (c <= len);
            exp_done = (c == len);
            exp_pass = (c >= len) && (cum_err[nv] == 0);
            total += 6;
            if ({oa, ob} !== exp_ab) begin
                bad++; $display("FAIL %s ab c=%0d got=%b want=%b", name, c, {oa, ob}, exp_ab);
            end
            if (obusy !== exp_busy) begin
                bad++; $display("FAIL %s busy c=%0d got=%b want=%b", name, c, obusy, exp_busy);
            end
            if (odone !== exp_done) begin
                bad++; $display("FAIL %s done c=%0d got=%b want=%b", name, c, odone, exp_done);
            end
            if (opass !== exp_pass) begin
                bad++; $display("FAIL %s pass c=%0d got=%b want=%b", name, c, opass, exp_pass);
            end
            if (oerr !== 8'(cum_err[vd])) begin
                bad++; $display("FAIL %s err_cnt c=%0d got=%0d want=%0d", name, c, oerr, cum_err[vd]);
            end
            if (ofv !== cum_fv[vd]) begin
                bad++; $display("FAIL %s fail_vec c=%0d got=%b want=%b", name, c, ofv, cum_fv[vd]);
            end
`ifdef GATE_BIST_FAILLOG_EN
            total += 1;
            if ({offv, offab, offr} !== ((first_idx >= 0 && vd > first_idx) ?
                                          {1'b1, first_ab, first_resp} : 10'd0)) begin
                bad++; $display("FAIL %s faillog c=%0d got=%b/%b/%b want_idx=%0d ab=%b resp=%b",
                                name, c, offv, offab, offr, first_idx, first_ab, first_resp);
            end
`endif
            if (c == inj) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        noise = 7'd0;
    endtask

    task automatic clear_faults();
        m_s0 = 7'd0; m_s1 = 7'd0; m_inv = 7'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 2;
        if ({a0, b0, busy0, done0, pass0, err0, fv0} !== 20'd0) begin
            bad++; $display("FAIL reset dut0 got=%h want=0", {a0, b0, busy0, done0, pass0, err0, fv0});
        end
        if ({a1, b1, busy1, done1, pass1, err1, fv1} !== 14'd0) begin
            bad++; $display("FAIL reset dut1 got=%h want=0", {a1, b1, busy1, done1, pass1, err1, fv1});
        end
`ifdef GATE_BIST_FAILLOG_EN
        total += 1;
        if ({ffv0, ffab0, ffr0, ffv1, ffab1, ffr1} !== 20'd0) begin
            bad++; $display("FAIL reset faillog got=%h want=0", {ffv0, ffab0, ffr0, ffv1, ffab1, ffr1});
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ideal();
        clear_faults();
        sel = 1'b0; run_check("ideal_d0", -1, 1'b0);
        sel = 1'b1; run_check("ideal_d1", -1, 1'b1);
    endtask

    task automatic test_stuck_ay();
        clear_faults();
        m_s0 = 7'b0100000;
        sel = 1'b0;
        run_check("stuck_ay", -1, 1'b1);
        total += 3;
        if (err0 !== 8'd1) begin
            bad++; $display("FAIL stuck_ay err_cnt got=%0d want=1", err0);
        end
        if (fv0 !== 7'b0100000) begin
            bad++; $display("FAIL stuck_ay fail_vec got=%b want=0100000", fv0);
        end
        if (pass0 !== 1'b0) begin
            bad++; $display("FAIL stuck_ay pass got=%b want=0", pass0);
        end
    endtask

    task automatic test_saturation();
        clear_faults();
        m_inv = 7'b0000010;
        sel = 1'b1;
        run_check("xoy_inv_d1", -1, 1'b0);
        total += 1;
        if (err1 !== 2'd3) begin
            bad++; $display("FAIL xoy_inv_sat err_cnt got=%0d want=3", err1);
        end
        sel = 1'b0;
        run_check("xoy_inv_d0", -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        clear_faults();
        sel = 1'b0;
        run_check("restart_mid", 5, 1'b0);
        run_check("restart_done", 12, 1'b0);
        sel = 1'b1;
        run_check("restart_mid_d1", 7, 1'b0);
    endtask

    task automatic test_faillog();
        clear_faults();
        m_s1 = 7'b0001000;
        sel = 1'b0;
        run_check("nay_stuck1", -1, 1'b0);
        total += 1;
        if (err0 !== 8'd1) begin
            bad++; $display("FAIL nay_stuck1 err_cnt got=%0d want=1", err0);
        end
`ifdef GATE_BIST_FAILLOG_EN
        total += 1;
        if ({ffv0, ffab0} !== 3'b111) begin
            bad++; $display("FAIL nay_stuck1 first_fail got=%b%b want=111", ffv0, ffab0);
        end
`endif
    endtask

    task automatic test_reset_abort();
        m_inv = 7'b1111111;
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        total += 1;
        if ({a0, b0, busy0, done0, pass0, err0, fv0} !== 20'd0) begin
            bad++; $display("FAIL abort state got=%h want=0", {a0, b0, busy0, done0, pass0, err0, fv0});
        end
        for (int k = 0; k < 15; k++) begin
            total += 1;
            if ({done0, busy0} !== 2'b00) begin
                bad++; $display("FAIL abort idle k=%0d done/busy got=%b want=00", k, {done0, busy0});
            end
            @(posedge clk);
            #1;
        end
        clear_faults();
        run_check("after_abort", -1, 1'b0);
    endtask

    task automatic test_random_faults();
        for (int k = 0; k < 8; k++) begin
            sel   = k[0];
            m_s0  = 7'($urandom) & 7'($urandom);
            m_s1  = 7'($urandom) & 7'($urandom) & 7'($urandom);
            m_inv = 7'($urandom) & 7'($urandom);
            run_check("random", ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : -1, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        clear_faults();
        m_s0 = 7'b1000000;
        sel = 1'b0;
        run_check("b2b_first", -1, 1'b1);
        clear_faults();
        run_check("b2b_second", -1, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sel = 1'b0;
        noise = 7'd0;
        clear_faults();
        test_reset();
        test_ideal();
        test_stuck_ay();
        test_saturation();
        test_start_ignored();
        test_faillog();
        test_reset_abort();
        test_random_faults();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
